// File: rtl/cg_palette_out_if.sv
// Palette write port of cg_palette_out: byte-wide shadow-palette loads plus the pending-commit flag.
interface cg_palette_out_if #(
    parameter int COLOR_BITS = 4
);
    logic                  pal_wr;
    logic [COLOR_BITS+1:0] pal_addr;   // {entry, comp}
    logic [7:0]            pal_data;
    logic                  pal_pending;

    modport master (output pal_wr, pal_addr, pal_data, input  pal_pending);
    modport slave  (input  pal_wr, pal_addr, pal_data, output pal_pending);
endinterface

// File: rtl/cg_palette_out.sv
// ColourGenie palette lookup, 8-bit colour expansion and 2-stage video output pipeline.
// Define PALETTE_WRITE_EN to compile in the byte-loadable shadow palette committed at vblank start.
module cg_palette_out #(
    parameter int COLOR_BITS = 4,
    parameter int COMP_W     = 6
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ce_pix,
    input  logic                  pixel,
    input  logic [COLOR_BITS-1:0] color,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblank_in,
    input  logic                  vblank_in,
    cg_palette_out_if.slave       pal,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_hb,
    output logic                  vga_vb,
    output logic                  vga_de,
    output logic                  ce_out
);
    localparam int ENTRIES = 2 ** COLOR_BITS;

    typedef logic [COMP_W-1:0] comp_t;

    function automatic logic [17:0] default_rgb6(input int idx);
        case (idx)
            0:       default_rgb6 = {6'd23, 6'd23, 6'd23};
            1:       default_rgb6 = {6'd27, 6'd63, 6'd58};
            2:       default_rgb6 = {6'd50, 6'd9,  6'd23};
            3:       default_rgb6 = {6'd58, 6'd58, 6'd58};
            4:       default_rgb6 = {6'd63, 6'd60, 6'd15};
            5:       default_rgb6 = {6'd42, 6'd63, 6'd18};
            6:       default_rgb6 = {6'd58, 6'd27, 6'd10};
            7:       default_rgb6 = {6'd58, 6'd63, 6'd9};
            8:       default_rgb6 = {6'd11, 6'd20, 6'd63};
            9:       default_rgb6 = {6'd47, 6'd55, 6'd63};
            10:      default_rgb6 = {6'd49, 6'd19, 6'd63};
            11:      default_rgb6 = {6'd34, 6'd25, 6'd63};
            12:      default_rgb6 = {6'd35, 6'd35, 6'd35};
            13:      default_rgb6 = {6'd7,  6'd49, 6'd35};
            14:      default_rgb6 = {6'd38, 6'd8,  6'd63};
            15:      default_rgb6 = {6'd63, 6'd63, 6'd63};
            default: default_rgb6 = '0;
        endcase
    endfunction

    // MSB-first bit walk: truncates when COMP_W < 6, replicates when COMP_W > 6.
    function automatic comp_t default_comp(input int idx, input int comp);
        logic [17:0] rgb;
        logic [5:0]  v;
        comp_t       r;
        rgb = default_rgb6(idx);
        v   = (comp == 0) ? rgb[17:12] : (comp == 1) ? rgb[11:6] : rgb[5:0];
        for (int i = 0; i < COMP_W; i++) r[COMP_W-1-i] = v[5-(i%6)];
        return r;
    endfunction

    function automatic logic [7:0] expand(input comp_t c);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) e[7-i] = c[COMP_W-1-(i%COMP_W)];
        return e;
    endfunction

    logic                  ce1;
    logic                  s1_pixel, s1_hs, s1_vs, s1_hb, s1_vb;
    logic [COLOR_BITS-1:0] s1_color;
    comp_t                 look_r, look_g, look_b;
    logic                  unused_pal;

`ifdef PALETTE_WRITE_EN
    comp_t                 active [ENTRIES][3];
    comp_t                 shadow [ENTRIES][3];
    logic                  pending;
    logic                  vb_prev;
    logic                  commit;
    logic                  wr_en;
    logic [COLOR_BITS-1:0] wr_entry;
    logic [1:0]            wr_comp;

    assign wr_entry   = pal.pal_addr[COLOR_BITS+1:2];
    assign wr_comp    = pal.pal_addr[1:0];
    assign wr_en      = pal.pal_wr && (wr_comp != 2'd3);
    assign commit     = vblank_in && !vb_prev && pending;
    assign unused_pal = ^pal.pal_data;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: both palettes are explicitly reset because they must come back holding the default table.
            for (int e = 0; e < ENTRIES; e++) begin
                for (int c = 0; c < 3; c++) begin
                    active[e][c] <= default_comp(e, c);
                    shadow[e][c] <= default_comp(e, c);
                end
            end
            pending <= 1'b0;
            vb_prev <= 1'b0;
        end else begin
            vb_prev <= vblank_in;
            // A same-cycle write misses this commit and keeps pending set for the next vblank.
            if (commit) active <= shadow;
            if (wr_en) begin
                case (wr_comp)
                    2'd0:    shadow[wr_entry][0] <= pal.pal_data[7 -: COMP_W];
                    2'd1:    shadow[wr_entry][1] <= pal.pal_data[7 -: COMP_W];
                    default: shadow[wr_entry][2] <= pal.pal_data[7 -: COMP_W];
                endcase
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    assign pal.pal_pending = pending;

    always_comb begin
        look_r = active[s1_color][0];
        look_g = active[s1_color][1];
        look_b = active[s1_color][2];
    end
`else
    assign pal.pal_pending = 1'b0;
    assign unused_pal      = ^{pal.pal_wr, pal.pal_addr, pal.pal_data};

    always_comb begin
        look_r = default_comp(int'(s1_color), 0);
        look_g = default_comp(int'(s1_color), 1);
        look_b = default_comp(int'(s1_color), 2);
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ce1      <= 1'b0;
            ce_out   <= 1'b0;
            s1_color <= '0;
            s1_pixel <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_hb    <= 1'b0;
            s1_vb    <= 1'b0;
            vga_r    <= 8'd0;
            vga_g    <= 8'd0;
            vga_b    <= 8'd0;
            vga_hs   <= 1'b0;
            vga_vs   <= 1'b0;
            vga_hb   <= 1'b1;
            vga_vb   <= 1'b1;
        end else begin
            // NOTE: non-blocking so stage 2 consumes stage 1's pre-edge contents while stage 1 reloads.
            ce1    <= ce_pix;
            ce_out <= ce1;
            if (ce_pix) begin
                s1_color <= color;
                s1_pixel <= pixel;
                s1_hs    <= hsync_in;
                s1_vs    <= vsync_in;
                s1_hb    <= hblank_in;
                s1_vb    <= vblank_in;
            end
            if (ce1) begin
                vga_hs <= s1_hs;
                vga_vs <= s1_vs;
                vga_hb <= s1_hb;
                vga_vb <= s1_vb;
                if (!s1_pixel || s1_hb || s1_vb) begin
                    vga_r <= 8'd0;
                    vga_g <= 8'd0;
                    vga_b <= 8'd0;
                end else begin
                    vga_r <= expand(look_r);
                    vga_g <= expand(look_g);
                    vga_b <= expand(look_b);
                end
            end
        end
    end

    assign vga_de = ~(vga_hb | vga_vb);

endmodule

// File: tb/tb_cg_palette_out.sv
// Self-checking bench for cg_palette_out: directed scenarios then randomized pixels and palette loads
// against a table-plus-arithmetic reference model (follows PALETTE_WRITE_EN like the design).
module tb_cg_palette_out;
    localparam int COLOR_BITS = 4;
    localparam int COMP_W     = 6;
`ifdef PALETTE_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    localparam int DEF_PAL [16][3] = '{
        '{23, 23, 23}, '{27, 63, 58}, '{50,  9, 23}, '{58, 58, 58},
        '{63, 60, 15}, '{42, 63, 18}, '{58, 27, 10}, '{58, 63,  9},
        '{11, 20, 63}, '{47, 55, 63}, '{49, 19, 63}, '{34, 25, 63},
        '{35, 35, 35}, '{ 7, 49, 35}, '{38,  8, 63}, '{63, 63, 63}
    };

    logic                  clk_sys = 1'b0;
    logic                  reset, ce_pix, pixel;
    logic [COLOR_BITS-1:0] color;
    logic                  hsync_in, vsync_in, hblank_in, vblank_in;
    logic [7:0]            vga_r, vga_g, vga_b;
    logic                  vga_hs, vga_vs, vga_hb, vga_vb, vga_de, ce_out;

    cg_palette_out_if #(.COLOR_BITS(COLOR_BITS)) pal ();

    cg_palette_out #(.COLOR_BITS(COLOR_BITS), .COMP_W(COMP_W)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .pixel    (pixel),
        .color    (color),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .hblank_in(hblank_in),
        .vblank_in(vblank_in),
        .pal      (pal),
        .vga_r    (vga_r),
        .vga_g    (vga_g),
        .vga_b    (vga_b),
        .vga_hs   (vga_hs),
        .vga_vs   (vga_vs),
        .vga_hb   (vga_hb),
        .vga_vb   (vga_vb),
        .vga_de   (vga_de),
        .ce_out   (ce_out)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference state: palettes held as 6-bit component values.
    int m_act [16][3];
    int m_sh  [16][3];
    bit m_pend, m_vbp;
    int e_r, e_g, e_b;
    bit e_hs, e_vs, e_hb, e_vb;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp8(input int c6);
        return ((c6 << 2) | (c6 >> 4)) & 8'hFF;
    endfunction

    task automatic model_edge();
        int ent, cmp;
        if (reset) begin
            m_act  = DEF_PAL;
            m_sh   = DEF_PAL;
            m_pend = 1'b0;
            m_vbp  = 1'b0;
        end else begin
            if (WR_EN) begin
                if (vblank_in && !m_vbp && m_pend) begin
                    m_act  = m_sh;
                    m_pend = 1'b0;
                end
                ent = int'(pal.pal_addr[5:2]);
                cmp = int'(pal.pal_addr[1:0]);
                if (pal.pal_wr && cmp != 3) begin
                    m_sh[ent][cmp] = int'(pal.pal_data) >> 2;
                    m_pend = 1'b1;
                end
            end
            m_vbp = vblank_in;
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        @(negedge clk_sys);
    endtask

    task automatic pal_write(input int ent, input int cmp, input int data);
        pal.pal_wr   = 1'b1;
        pal.pal_addr = {4'(ent), 2'(cmp)};
        pal.pal_data = 8'(data);
        tick();
        pal.pal_wr   = 1'b0;
    endtask

    // One captured pixel; optionally a palette write and a vblank change during the lookup cycle.
    task automatic pixel_tx(input int col, input bit pix, input bit hs, input bit vs, input bit hb,
                            input bit vb_mid, input bit wr, input int waddr, input int wdata);
        bit vb_cap, blank;
        int er, eg, eb;
        color     = COLOR_BITS'(col);
        pixel     = pix;
        hsync_in  = hs;
        vsync_in  = vs;
        hblank_in = hb;
        ce_pix    = 1'b1;
        vb_cap    = vblank_in;
        tick();
        ce_pix = 1'b0;
        check("ce_out_early", ce_out, 0);
        check("hs_not_early", vga_hs, e_hs);
        check("r_not_early",  vga_r,  e_r);
        color     = COLOR_BITS'($urandom);
        pixel     = 1'($urandom);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        hblank_in = 1'($urandom);
        vblank_in = vb_mid;
        pal.pal_wr   = wr;
        pal.pal_addr = 6'(waddr);
        pal.pal_data = 8'(wdata);
        blank = !pix || hb || vb_cap;
        er = blank ? 0 : exp8(m_act[col][0]);
        eg = blank ? 0 : exp8(m_act[col][1]);
        eb = blank ? 0 : exp8(m_act[col][2]);
        tick();
        pal.pal_wr = 1'b0;
        e_r = er; e_g = eg; e_b = eb;
        e_hs = hs; e_vs = vs; e_hb = hb; e_vb = vb_cap;
        check("ce_out",  ce_out, 1);
        check("vga_r",   vga_r,  e_r);
        check("vga_g",   vga_g,  e_g);
        check("vga_b",   vga_b,  e_b);
        check("vga_hs",  vga_hs, e_hs);
        check("vga_vs",  vga_vs, e_vs);
        check("vga_hb",  vga_hb, e_hb);
        check("vga_vb",  vga_vb, e_vb);
        check("vga_de",  vga_de, !(e_hb || e_vb));
        check("pending", pal.pal_pending, m_pend);
        tick();
        check("ce_out_low", ce_out, 0);
        check("r_hold",  vga_r,  e_r);
        check("g_hold",  vga_g,  e_g);
        check("b_hold",  vga_b,  e_b);
        check("hs_hold", vga_hs, e_hs);
    endtask

    task automatic tx(input int col, input bit pix, input bit hs, input bit hb);
        pixel_tx(col, pix, hs, 1'b0, hb, vblank_in, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce_pix = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        e_r = 0; e_g = 0; e_b = 0;
        e_hs = 0; e_vs = 0; e_hb = 1; e_vb = 1;
        check("rst_r",   vga_r,  0);
        check("rst_g",   vga_g,  0);
        check("rst_b",   vga_b,  0);
        check("rst_hs",  vga_hs, 0);
        check("rst_vs",  vga_vs, 0);
        check("rst_hb",  vga_hb, 1);
        check("rst_vb",  vga_vb, 1);
        check("rst_de",  vga_de, 0);
        check("rst_ce",  ce_out, 0);
        check("rst_pending", pal.pal_pending, 0);
    endtask

    task automatic vblank_pulse();
        vblank_in = 1'b1;
        tick();
        vblank_in = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b0; pixel = 1'b0; color = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblank_in = 1'b0; vblank_in = 1'b0;
        pal.pal_wr = 1'b0; pal.pal_addr = '0; pal.pal_data = '0;
        @(negedge clk_sys);
        do_reset();

        // Basic lookups, pixel-off and hblank blanking with sync delay.
        tx(15, 1'b1, 1'b0, 1'b0);
        tx(0,  1'b1, 1'b0, 1'b0);
        tx(0,  1'b0, 1'b0, 1'b0);
        tx(2,  1'b1, 1'b1, 1'b1);
        tx(2,  1'b1, 1'b0, 1'b0);

        // Shadow load mid-frame, visible only after vblank rise.
        pal_write(2, 0, 8'hFC);
        pal_write(2, 1, 8'h00);
        pal_write(2, 2, 8'h00);
        check("pend_after_wr", pal.pal_pending, m_pend);
        tx(2, 1'b1, 1'b0, 1'b0);
        vblank_pulse();
        check("pend_after_commit", pal.pal_pending, m_pend);
        tx(2, 1'b1, 1'b0, 1'b0);

        // Write coinciding with the vblank rise misses that commit.
        pal_write(5, 1, 8'h40);
        vblank_in = 1'b1;
        pal_write(7, 0, 8'h80);
        check("pend_coincide", pal.pal_pending, m_pend);
        vblank_in = 1'b0;
        tick();
        tx(5, 1'b1, 1'b0, 1'b0);
        tx(7, 1'b1, 1'b0, 1'b0);
        vblank_pulse();
        tx(7, 1'b1, 1'b0, 1'b0);

        // Lookup in the same cycle as a commit sees the old entry.
        pal_write(9, 2, 8'h00);
        pixel_tx(9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        vblank_in = 1'b0;
        tick();
        tx(9, 1'b1, 1'b0, 1'b0);

        // Reset discards pending shadow writes.
        pal_write(2, 1, 8'hFF);
        do_reset();
        tx(2, 1'b1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 2) == 0)
                pal_write($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 255));
            if (vblank_in) begin
                if ($urandom_range(0, 1) == 0) vblank_in = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                vblank_in = 1'b1;
            end
            pixel_tx($urandom_range(0, 15), ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 9) == 0) ? ~vblank_in : vblank_in,
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 63), $urandom_range(0, 255));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
